// File: rtl/mem8_regfile_pkg.sv
// Shared constants and types for the mem_8 seekable-stream register file.
// The optional end-of-file behaviour is selected with MEM8_EOF_AT_END_EN.
package mem8_pkg;

  localparam int MEM8_AW      = 5;
  localparam int MEM8_DEPTH   = 2 ** MEM8_AW;
  localparam int MEM8_RO_BASE = 16;

  typedef logic [7:0] mem8_byte_t;

  localparam mem8_byte_t MEM8_CTRL_INIT = 8'h00;

endpackage

// File: rtl/mem8_regfile_if.sv
// Core-side signals of the seekable 8-bit stream: seek, write path and read path.
// master = Xillybus core side, slave = user-side responder.
interface mem8_regfile_if #(
  parameter int AW = mem8_pkg::MEM8_AW
);
  import mem8_pkg::*;

  logic [AW-1:0] user_mem_8_addr_w;
  logic          user_mem_8_addr_update_w;

  logic          user_w_mem_8_open_w;
  logic          user_w_mem_8_wren_w;
  mem8_byte_t    user_w_mem_8_data_w;
  logic          user_w_mem_8_full_w;

  logic          user_r_mem_8_open_w;
  logic          user_r_mem_8_rden_w;
  mem8_byte_t    user_r_mem_8_data_w;
  logic          user_r_mem_8_empty_w;
  logic          user_r_mem_8_eof_w;

  modport master (
    output user_mem_8_addr_w, user_mem_8_addr_update_w,
    output user_w_mem_8_open_w, user_w_mem_8_wren_w, user_w_mem_8_data_w,
    input  user_w_mem_8_full_w,
    output user_r_mem_8_open_w, user_r_mem_8_rden_w,
    input  user_r_mem_8_data_w, user_r_mem_8_empty_w, user_r_mem_8_eof_w
  );

  modport slave (
    input  user_mem_8_addr_w, user_mem_8_addr_update_w,
    input  user_w_mem_8_open_w, user_w_mem_8_wren_w, user_w_mem_8_data_w,
    output user_w_mem_8_full_w,
    input  user_r_mem_8_open_w, user_r_mem_8_rden_w,
    output user_r_mem_8_data_w, user_r_mem_8_empty_w, user_r_mem_8_eof_w
  );

endinterface

// File: rtl/mem8_regfile.sv
// Byte register file behind the seekable mem_8 stream: control bytes out to fabric,
// live status bytes back to the host. Optional MEM8_EOF_AT_END_EN stops reads at the last address.
module mem8_regfile
  import mem8_pkg::*;
#(
  parameter int         AW        = MEM8_AW,
  parameter int         RO_BASE   = MEM8_RO_BASE,
  parameter mem8_byte_t CTRL_INIT = MEM8_CTRL_INIT
) (
  input  logic                           bus_clk_w,
  input  logic                           bus_rst_n_w,
  mem8_regfile_if.slave                  bus,
  input  logic [8*((2**AW)-RO_BASE)-1:0] status_in,
  output logic [8*RO_BASE-1:0]           ctrl_out,
  output logic                           ctrl_wr_pulse,
  output logic [AW-1:0]                  ctrl_wr_addr
);

  localparam int DEPTH = 2 ** AW;
  localparam int NSTAT = DEPTH - RO_BASE;
  localparam int CW    = (RO_BASE > 1) ? $clog2(RO_BASE) : 1;
  localparam int SW    = (NSTAT > 1) ? $clog2(NSTAT) : 1;
  localparam logic [AW-1:0] RO_BASE_A = AW'(RO_BASE);
  localparam logic [AW-1:0] LAST_A    = AW'(DEPTH - 1);

  mem8_byte_t    ctrl_q [RO_BASE];
  mem8_byte_t    stat_b [NSTAT];
  logic [AW-1:0] ptr_q;
  mem8_byte_t    r_data_q;
  logic          full_q;
  logic          closed_q;
  logic          eof_q;

  logic          empty;
  logic          wr_acc;
  logic          rd_acc;
  logic          in_ctrl;
  logic [AW-1:0] sidx_full;
  logic [CW-1:0] cidx;
  logic [SW-1:0] sidx;
  mem8_byte_t    rd_byte;

  for (genvar k = 0; k < RO_BASE; k++) begin : g_ctrl
    assign ctrl_out[k*8 +: 8] = ctrl_q[k];
  end

  for (genvar k = 0; k < NSTAT; k++) begin : g_stat
    assign stat_b[k] = status_in[k*8 +: 8];
  end

  assign empty     = closed_q | eof_q;
  assign in_ctrl   = (ptr_q < RO_BASE_A);
  assign cidx      = ptr_q[CW-1:0];
  assign sidx_full = ptr_q - RO_BASE_A;
  assign sidx      = sidx_full[SW-1:0];

  // A seek in the same cycle swallows any byte strobe.
  assign wr_acc = bus.user_w_mem_8_wren_w & bus.user_w_mem_8_open_w
                & ~bus.user_mem_8_addr_update_w;
  assign rd_acc = bus.user_r_mem_8_rden_w & bus.user_r_mem_8_open_w & ~empty
                & ~bus.user_mem_8_addr_update_w;

  always_comb begin
    rd_byte = 8'h00;
    if (in_ctrl) rd_byte = ctrl_q[cidx];
    else         rd_byte = stat_b[sidx];
  end

  always_ff @(posedge bus_clk_w or negedge bus_rst_n_w) begin
    if (!bus_rst_n_w) begin
      ptr_q         <= '0;
      full_q        <= 1'b1;
      closed_q      <= 1'b1;
      r_data_q      <= 8'h00;
      ctrl_wr_pulse <= 1'b0;
      ctrl_wr_addr  <= '0;
      for (int i = 0; i < RO_BASE; i++) ctrl_q[i] <= CTRL_INIT;
    end else begin
      full_q        <= 1'b0;
      closed_q      <= ~bus.user_r_mem_8_open_w;
      ctrl_wr_pulse <= 1'b0;

      if (bus.user_mem_8_addr_update_w) ptr_q <= bus.user_mem_8_addr_w;
      else if (wr_acc | rd_acc)         ptr_q <= ptr_q + AW'(1);

      // Writes into the status window are dropped but still advance the pointer.
      if (wr_acc && in_ctrl) begin
        ctrl_q[cidx]  <= bus.user_w_mem_8_data_w;
        ctrl_wr_pulse <= 1'b1;
        ctrl_wr_addr  <= ptr_q;
      end

      if (rd_acc) r_data_q <= rd_byte;
    end
  end

`ifdef MEM8_EOF_AT_END_EN
  always_ff @(posedge bus_clk_w or negedge bus_rst_n_w) begin
    if (!bus_rst_n_w)                                                  eof_q <= 1'b0;
    else if (bus.user_mem_8_addr_update_w || !bus.user_r_mem_8_open_w) eof_q <= 1'b0;
    else if (rd_acc && (ptr_q == LAST_A))                              eof_q <= 1'b1;
  end
`else
  assign eof_q = 1'b0;
`endif

  assign bus.user_w_mem_8_full_w  = full_q;
  assign bus.user_r_mem_8_data_w  = r_data_q;
  assign bus.user_r_mem_8_empty_w = empty;
  assign bus.user_r_mem_8_eof_w   = eof_q;

endmodule

// File: tb/tb_mem8_regfile.sv
// Scoreboard bench for mem8_regfile: a byte-array model predicts reads and control-write pulses,
// an independent monitor pops and compares whenever the DUT presents them.
module tb_mem8_regfile;
  import mem8_pkg::*;

  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int RO    = 16;
  localparam int NS    = DEPTH - RO;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem8_regfile_if #(.AW(AW)) bus ();
  logic [8*NS-1:0] status_in;
  logic [8*RO-1:0] ctrl_out;
  logic            ctrl_wr_pulse;
  logic [AW-1:0]   ctrl_wr_addr;

  mem8_regfile #(.AW(AW), .RO_BASE(RO), .CTRL_INIT(8'h00)) dut (
    .bus_clk_w     (clk),
    .bus_rst_n_w   (rst_n),
    .bus           (bus),
    .status_in     (status_in),
    .ctrl_out      (ctrl_out),
    .ctrl_wr_pulse (ctrl_wr_pulse),
    .ctrl_wr_addr  (ctrl_wr_addr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic note_unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT output with no expected entry (t=%0t)", name, $time);
  endtask

  // Reference model: plain byte arrays plus the stream pointer
  logic [7:0] m_ctrl [RO];
  logic [7:0] m_stat [NS];
  int         m_ptr;
  bit         m_closed;
  bit         m_eof;

  typedef struct { int a; logic [7:0] d; } wr_t;
  logic [7:0] rd_q [$];
  wr_t        wr_q [$];

  task automatic model_reset();
    m_ptr = 0;
    m_closed = 1'b1;
    m_eof = 1'b0;
    for (int i = 0; i < RO; i++) m_ctrl[i] = 8'h00;
    rd_q.delete();
    wr_q.delete();
  endtask

  task automatic drive_idle();
    bus.user_mem_8_addr_w        = '0;
    bus.user_mem_8_addr_update_w = 1'b0;
    bus.user_w_mem_8_open_w      = 1'b0;
    bus.user_w_mem_8_wren_w      = 1'b0;
    bus.user_w_mem_8_data_w      = 8'h00;
    bus.user_r_mem_8_open_w      = 1'b0;
    bus.user_r_mem_8_rden_w      = 1'b0;
  endtask

  task automatic push_status();
    for (int k = 0; k < NS; k++) status_in[k*8 +: 8] = m_stat[k];
  endtask

  task automatic chk_reset();
    check("rst_full",    32'(bus.user_w_mem_8_full_w),  1);
    check("rst_empty",   32'(bus.user_r_mem_8_empty_w), 1);
    check("rst_eof",     32'(bus.user_r_mem_8_eof_w),   0);
    check("rst_rdata",   32'(bus.user_r_mem_8_data_w),  0);
    check("rst_pulse",   32'(ctrl_wr_pulse),            0);
    check("rst_wr_addr", 32'(ctrl_wr_addr),             0);
    for (int k = 0; k < RO; k++) check("rst_ctrl_out", 32'(ctrl_out[k*8 +: 8]), 0);
  endtask

  // One bus cycle: check registered outputs, drive inputs, advance the model to the next edge.
  task automatic cyc(input bit au, input int addr, input bit wo, input bit wr,
                     input logic [7:0] wd, input bit ro, input bit rd);
    bit rd_ok, wr_ok, m_empty;
    @(posedge clk);
    #1;
    m_empty = m_closed | m_eof;
    check("empty", 32'(bus.user_r_mem_8_empty_w), 32'(m_empty));
    check("eof",   32'(bus.user_r_mem_8_eof_w),   32'(m_eof));
    check("full",  32'(bus.user_w_mem_8_full_w),  0);
    for (int k = 0; k < RO; k++) check("ctrl_out", 32'(ctrl_out[k*8 +: 8]), 32'(m_ctrl[k]));

    bus.user_mem_8_addr_w        = AW'(addr);
    bus.user_mem_8_addr_update_w = au;
    bus.user_w_mem_8_open_w      = wo;
    bus.user_w_mem_8_wren_w      = wr;
    bus.user_w_mem_8_data_w      = wd;
    bus.user_r_mem_8_open_w      = ro;
    bus.user_r_mem_8_rden_w      = rd;
    push_status();

    rd_ok = rd && ro && !m_empty && !au;
    wr_ok = wr && wo && !au;
    if (rd_ok) rd_q.push_back((m_ptr < RO) ? m_ctrl[m_ptr] : m_stat[m_ptr - RO]);
`ifdef MEM8_EOF_AT_END_EN
    if (au || !ro)                        m_eof = 1'b0;
    else if (rd_ok && m_ptr == DEPTH - 1) m_eof = 1'b1;
`endif
    if (wr_ok && m_ptr < RO) begin
      wr_q.push_back('{a: m_ptr, d: wd});
      m_ctrl[m_ptr] = wd;
    end
    if (au)                 m_ptr = addr;
    else if (rd_ok || wr_ok) m_ptr = (m_ptr + 1) % DEPTH;
    m_closed = !ro;
  endtask

  // Monitor: r_data is presented the cycle after an accepted rden; pulses carry addr + ctrl_out.
  bit pend_rd = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend_rd = 1'b0;
      end else begin
        if (pend_rd) begin
          if (rd_q.size() == 0) note_unexpected("r_data");
          else check("r_data", 32'(bus.user_r_mem_8_data_w), 32'(rd_q.pop_front()));
        end
        if (ctrl_wr_pulse) begin
          if (wr_q.size() == 0) note_unexpected("ctrl_wr_pulse");
          else begin
            wr_t e;
            e = wr_q.pop_front();
            check("ctrl_wr_addr", 32'(ctrl_wr_addr), 32'(e.a));
            check("ctrl_wr_byte", 32'(ctrl_out[e.a*8 +: 8]), 32'(e.d));
          end
        end
        pend_rd = bus.user_r_mem_8_rden_w & bus.user_r_mem_8_open_w
                & ~bus.user_r_mem_8_empty_w & ~bus.user_mem_8_addr_update_w;
      end
    end
  end

  initial begin
    drive_idle();
    for (int k = 0; k < NS; k++) m_stat[k] = 8'($urandom);
    push_status();
    model_reset();

    // 1: reset state, full released one clock after reset deasserts
    @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    #1;
    check("full_after_release", 32'(bus.user_w_mem_8_full_w), 1);
    cyc(0, 0, 0, 0, 8'h00, 0, 0);

    // 2: seek 3 and write three control bytes
    cyc(1, 3, 1, 0, 8'h00, 0, 0);
    cyc(0, 0, 1, 1, 8'hAA, 0, 0);
    cyc(0, 0, 1, 1, 8'hBB, 0, 0);
    cyc(0, 0, 1, 1, 8'hCC, 0, 0);
    cyc(0, 0, 1, 0, 8'h00, 0, 0);

    // 3: first status byte
    m_stat[0] = 8'h5A;
    cyc(1, 16, 0, 0, 8'h00, 1, 0);
    cyc(0, 0, 0, 0, 8'h00, 1, 1);
    cyc(0, 0, 0, 0, 8'h00, 1, 1);
    cyc(0, 0, 0, 0, 8'h00, 1, 0);

    // 4: write into status window is dropped
    cyc(1, 20, 1, 0, 8'h00, 1, 0);
    cyc(0, 0, 1, 1, 8'h77, 1, 0);
    cyc(1, 20, 1, 0, 8'h00, 1, 0);
    cyc(0, 0, 1, 0, 8'h00, 1, 1);
    cyc(0, 0, 1, 0, 8'h00, 1, 0);

    // 5: reading across the top address
    cyc(1, 31, 0, 0, 8'h00, 1, 0);
    cyc(0, 0, 0, 0, 8'h00, 1, 1);
    cyc(0, 0, 0, 0, 8'h00, 1, 1);
    cyc(0, 0, 0, 0, 8'h00, 1, 0);
    cyc(1, 0, 0, 0, 8'h00, 1, 0);
    cyc(0, 0, 0, 0, 8'h00, 1, 1);
    cyc(0, 0, 0, 0, 8'h00, 1, 0);

    // 6: seek wins over a same-cycle write; next write lands at the seek target
    cyc(1, 2, 1, 0, 8'h00, 1, 0);
    cyc(1, 8, 1, 1, 8'hE7, 1, 0);
    cyc(0, 0, 1, 1, 8'h11, 1, 0);
    cyc(1, 2, 1, 0, 8'h00, 1, 0);
    cyc(0, 0, 1, 0, 8'h00, 1, 1);
    cyc(0, 0, 1, 0, 8'h00, 1, 0);

    // Read+write at the same pointer returns the pre-write byte
    cyc(1, 5, 1, 0, 8'h00, 1, 0);
    cyc(0, 0, 1, 1, 8'h3C, 1, 1);
    cyc(0, 0, 1, 0, 8'h00, 1, 0);

    // Random traffic, live status bytes changing underneath
    for (int n = 0; n < 400; n++) begin
      m_stat[$urandom_range(0, NS - 1)] = 8'($urandom);
      cyc(($urandom_range(0, 7) == 0), int'($urandom_range(0, DEPTH - 1)),
          ($urandom_range(0, 7) != 0), 1'($urandom), 8'($urandom),
          ($urandom_range(0, 9) != 0), 1'($urandom));
    end

    // Async reset in the middle of a write burst
    cyc(1, 0, 1, 0, 8'h00, 1, 0);
    for (int n = 0; n < 4; n++) cyc(0, 0, 1, 1, 8'($urandom | 1), 1, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive_idle();
    #1;
    chk_reset();
    model_reset();
    @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    #1;
    check("full_after_mid_reset", 32'(bus.user_w_mem_8_full_w), 1);

    for (int n = 0; n < 200; n++) begin
      m_stat[$urandom_range(0, NS - 1)] = 8'($urandom);
      cyc(($urandom_range(0, 7) == 0), int'($urandom_range(0, DEPTH - 1)),
          ($urandom_range(0, 7) != 0), 1'($urandom), 8'($urandom),
          ($urandom_range(0, 9) != 0), 1'($urandom));
    end

    cyc(0, 0, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 0, 8'h00, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("rd_left_over", 32'(rd_q.size()), 0);
    check("wr_left_over", 32'(wr_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
